// File: rtl/multdiv_pkg.sv
// Shared types for the multdiv unit: FSM states, default width and Booth op encoding.
package multdiv_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP,
    BOOTH_ADD,
    BOOTH_SUB
  } booth_op_t;

  // Pair is {Q0, Q-1}: 01 ends a run of ones (add), 10 starts one (subtract).
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    case (pair)
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into acc, then arithmetic
// shift right of {acc, Q, Q-1}. Purely combinational.
module booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  booth_op_t      op;
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    op    = booth_decode({q[0], q_m1});
    m_ext = {m[WIDTH-1], m};
    case (op)
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
  end

  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_multiply.sv
// Sequential signed radix-2 Booth multiplier, WIDTH cycles from do_mult to value_ready.
// Define MULT_HI_EN to expose the upper product half on out_hi.
module booth_multiply
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             do_mult,
  output logic             busy,
  output logic             value_ready,
  output logic             exception,
`ifdef MULT_HI_EN
  output logic [WIDTH-1:0] out_hi,
`endif
  output logic [WIDTH-1:0] out
);

  localparam int             CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] q_nx;
  logic             q_m1_nx;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .m         (m_reg),
    .acc_next  (acc_nx),
    .q_next    (q_nx),
    .q_m1_next (q_m1_nx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      value_ready <= 1'b0;
      exception   <= 1'b0;
      out         <= '0;
`ifdef MULT_HI_EN
      out_hi      <= '0;
`endif
      counter     <= '0;
      m_reg       <= '0;
      acc         <= '0;
      q           <= '0;
      q_m1        <= 1'b0;
    end else begin
      value_ready <= 1'b0;
      // A new start wins in every state, which also aborts a running operation.
      if (do_mult) begin
        m_reg     <= A;
        acc       <= '0;
        q         <= B;
        q_m1      <= 1'b0;
        counter   <= '0;
        state     <= RUN;
        busy      <= 1'b1;
        exception <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            acc     <= acc_nx;
            q       <= q_nx;
            q_m1    <= q_m1_nx;
            counter <= counter + 1'b1;
            if (counter == LAST) begin
              state       <= DONE;
              busy        <= 1'b0;
              value_ready <= 1'b1;
              out         <= q_nx;
`ifdef MULT_HI_EN
              out_hi      <= acc_nx[WIDTH-1:0];
`endif
              // Product fits iff the upper half is pure sign extension of the lower half.
              exception   <= (acc_nx[WIDTH-1:0] != {WIDTH{q_nx[WIDTH-1]}});
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_booth_multiply.sv
// Scoreboard bench for booth_multiply: expected products from a native 64-bit signed model.
module tb_booth_multiply;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         do_mult = 1'b0;
  logic         busy;
  logic         value_ready;
  logic         exception;
  logic [W-1:0] out;
  logic [W-1:0] out_hi_obs;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  booth_multiply #(.WIDTH(W)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .A           (A),
    .B           (B),
    .do_mult     (do_mult),
    .busy        (busy),
    .value_ready (value_ready),
    .exception   (exception),
`ifdef MULT_HI_EN
    .out_hi      (out_hi_obs),
`endif
    .out         (out)
  );

`ifndef MULT_HI_EN
  assign out_hi_obs = '0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic signed [63:0] p;
    logic [63:0] sext_lo;
    p       = 64'($signed(a)) * 64'($signed(b));
    sext_lo = {{32{p[31]}}, p[31:0]};
    e.lo    = p[31:0];
    e.hi    = p[63:32];
    e.exc   = (p != sext_lo);
    return e;
  endfunction

  // Every value_ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (value_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_value_ready", 64'(value_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("out", 64'(out), 64'(e.lo));
        check_eq("exception", 64'(exception), 64'(e.exc));
`ifdef MULT_HI_EN
        check_eq("out_hi", 64'(out_hi_obs), 64'(e.hi));
`endif
      end
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_done);
    @(negedge clk);
    A       = a;
    B       = b;
    do_mult = 1'b1;
    if (expect_done) sb.push_back(model(a, b));
    @(negedge clk);
    do_mult = 1'b0;
  endtask

  // Called at the negedge right after the start edge; counts edges to value_ready.
  task automatic wait_done(input string tag);
    int lat;
    bit got;
    lat = 0;
    got = 0;
    check_eq({tag, "_busy_run"}, 64'(busy), 64'd1);
    while (!got && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (value_ready) got = 1;
    end
    check_eq({tag, "_done_seen"}, 64'(got), 64'd1);
    check_eq({tag, "_latency"}, 64'(lat), 64'd32);
    check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    start(a, b, 1'b1);
    wait_done(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_vr", 64'(value_ready), 64'd0);
    check_eq("rst_exc", 64'(exception), 64'd0);
    check_eq("rst_out", 64'(out), 64'd0);
    check_eq("rst_out_hi", 64'(out_hi_obs), 64'd0);
    resetn = 1'b1;

    run_op("3x5", 32'd3, 32'd5);
    run_op("m7x6", 32'hFFFF_FFF9, 32'd6);
    run_op("big", 32'h0001_0000, 32'h0001_0000);
    run_op("minxm1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("minx1", 32'h8000_0000, 32'd1);
    run_op("zero", 32'd0, 32'h1234_5678);
    run_op("minxmin", 32'h8000_0000, 32'h8000_0000);

    // Restart mid-operation: 2x3 must never report.
    start(32'd2, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    start(32'd4, 32'd5, 1'b1);
    wait_done("restart");

    // Reset mid-operation clears every output at once.
    start(32'd5, 32'd7, 1'b0);
    repeat (13) @(negedge clk);
    resetn = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_vr", 64'(value_ready), 64'd0);
    check_eq("midrst_exc", 64'(exception), 64'd0);
    check_eq("midrst_out", 64'(out), 64'd0);
    check_eq("midrst_out_hi", 64'(out_hi_obs), 64'd0);
    repeat (40) @(negedge clk);
    resetn = 1'b1;
    run_op("9x9", 32'd9, 32'd9);

    for (int i = 0; i < 6; i++) begin
      run_op("rand", $urandom, (i % 2 == 0) ? 32'($urandom_range(0, 1000)) : $urandom);
    end

    // Output hold: no new start, result and flag stay put.
    repeat (40) @(negedge clk);
    check_eq("idle_vr", 64'(value_ready), 64'd0);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
